// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage data-memory sequencer. Takes one load/store op from the pipeline
//   latch, issues the request(s) to data memory (two for LDI/STI: pointer
//   fetch then access), returns the load result and pulses mem_done.
//
//   States:
//     IDLE   | waiting for a live op; stall only while accepting one
//     PTR    | reading the pointer word for LDI/STI
//     ACCESS | data read or write outstanding
//     DONE   | one-cycle completion, stall released
//
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     mem_valid, mem_op           live-op flag and operation code
//     mem_address, mem_wdata      effective address, store data
//     dmem_read, dmem_write       memory request strobes (registered)
//     dmem_address, dmem_wdata    word-aligned address, lane-replicated data
//     dmem_byte_enable            store lanes {high, low}
//     dmem_rdata, dmem_resp       read data and completion pulse
//     mem_rdata, mem_done         load result, completion pulse
//     mem_stall                   pipeline freeze
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [2:0]  mem_op,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [15:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_stall
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LDR  = 3'd1;
  localparam logic [2:0] OP_LDB  = 3'd2;
  localparam logic [2:0] OP_STR  = 3'd3;
  localparam logic [2:0] OP_STB  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_STI  = 3'd6;

  typedef enum logic [1:0] {IDLE, PTR, ACCESS, DONE} state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic        addr_lsb_q;   // only the byte-select bit is needed after issue
  logic [15:0] wdata_q;
  logic        accept;

  assign accept    = mem_valid && (mem_op != OP_NONE) && (mem_op != 3'd7);
  assign mem_stall = (state == PTR) || (state == ACCESS) || ((state == IDLE) && accept);

  function automatic logic is_load(input logic [2:0] op);
    return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI);
  endfunction

  function automatic logic [1:0] store_lanes(input logic [2:0] op, input logic lsb);
    if (op == OP_STR || op == OP_STI) return 2'b11;
    if (op == OP_STB)                 return lsb ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [15:0] store_data(input logic [2:0] op, input logic [15:0] w);
    return (op == OP_STB) ? {w[7:0], w[7:0]} : w;
  endfunction

  function automatic logic [15:0] load_data(input logic [2:0] op, input logic lsb,
                                            input logic [15:0] r);
    if (op == OP_LDB)
      return lsb ? {{8{r[15]}}, r[15:8]} : {{8{r[7]}}, r[7:0]};
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      op_q             <= OP_NONE;
      addr_lsb_q       <= 1'b0;
      wdata_q          <= '0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
      mem_rdata        <= '0;
      mem_done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_done <= 1'b0;
          if (accept) begin
            op_q         <= mem_op;
            addr_lsb_q   <= mem_address[0];
            wdata_q      <= mem_wdata;
            dmem_address <= {mem_address[15:1], 1'b0};
            if (mem_op == OP_LDI || mem_op == OP_STI) begin
              state     <= PTR;
              dmem_read <= 1'b1;
            end else begin
              state            <= ACCESS;
              dmem_read        <= is_load(mem_op);
              dmem_write       <= !is_load(mem_op);
              dmem_wdata       <= store_data(mem_op, mem_wdata);
              dmem_byte_enable <= store_lanes(mem_op, mem_address[0]);
            end
          end
        end
        PTR: begin
          if (dmem_resp) begin
            // The pointer word becomes the effective address of a plain LDR/STR.
            state            <= ACCESS;
            op_q             <= (op_q == OP_LDI) ? OP_LDR : OP_STR;
            addr_lsb_q       <= dmem_rdata[0];
            dmem_address     <= {dmem_rdata[15:1], 1'b0};
            dmem_read        <= (op_q == OP_LDI);
            dmem_write       <= (op_q != OP_LDI);
            dmem_wdata       <= wdata_q;
            dmem_byte_enable <= (op_q == OP_LDI) ? 2'b00 : 2'b11;
          end
        end
        ACCESS: begin
          if (dmem_resp) begin
            state            <= DONE;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_byte_enable <= 2'b00;
            mem_done         <= 1'b1;
            if (is_load(op_q))
              mem_rdata <= load_data(op_q, addr_lsb_q, dmem_rdata);
          end
        end
        DONE: begin
          mem_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
